// File: rtl/adder64_rr_sched.sv
// Round-robin scheduler that shares one 64-bit Kogge-Stone adder among NREQ requesters.
// Optional feature: define ADDARB_OVF_EN to add the rsp_ovf two's-complement overflow output.

module adder64 (
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic        i_c0,
   output logic [63:0] o_sum,
   output logic        o_c64
);

   logic [64:0] w_carry;

   // Six prefix levels merge (generate, propagate) pairs over spans 1,2,4,...,32
   for (genvar lvl = 0; lvl <= 6; lvl++) begin : g_stage
      logic [63:0] w_g;
      logic [63:0] w_p;
      if (lvl == 0) begin : g_init
         assign w_g = i_a & i_b;
         assign w_p = i_a ^ i_b;
      end else begin : g_merge
         localparam int DIST = 1 << (lvl - 1);
         for (genvar i = 0; i < 64; i++) begin : g_bit
            if (i >= DIST) begin : g_combine
               assign w_g[i] = g_stage[lvl-1].w_g[i]
                             | (g_stage[lvl-1].w_p[i] & g_stage[lvl-1].w_g[i-DIST]);
               assign w_p[i] = g_stage[lvl-1].w_p[i] & g_stage[lvl-1].w_p[i-DIST];
            end else begin : g_pass
               assign w_g[i] = g_stage[lvl-1].w_g[i];
               assign w_p[i] = g_stage[lvl-1].w_p[i];
            end
         end
      end
   end

   assign w_carry[0] = i_c0;
   for (genvar i = 0; i < 64; i++) begin : g_carry
      assign w_carry[i+1] = g_stage[6].w_g[i] | (g_stage[6].w_p[i] & i_c0);
   end

   assign o_sum = g_stage[0].w_p ^ w_carry[63:0];
   assign o_c64 = w_carry[64];

endmodule

module adder64_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*64-1:0]   req_a,
   input  logic [NREQ*64-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [63:0]          rsp_sum,
`ifdef ADDARB_OVF_EN
   output logic                 rsp_cout,
   output logic                 rsp_ovf
`else
   output logic                 rsp_cout
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_RESP
   } state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_idQ;
   logic [63:0]     r_aQ;
   logic [63:0]     r_bQ;
   logic            r_rspValid;
   logic [IDW-1:0]  r_rspId;
   logic [63:0]     r_rspSum;
   logic            r_rspCout;

   logic            w_found;
   logic [IDW-1:0]  w_winner;
   logic [IDW-1:0]  w_probe;
   logic [IDW-1:0]  w_ptrNext;
   logic [NREQ-1:0] w_grant;
   logic [63:0]     w_selA;
   logic [63:0]     w_selB;
   logic [63:0]     w_sum;
   logic            w_c64;

   // Search starting at the pointer so the last winner drops to lowest priority
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_probe  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_probe = IDW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req_valid[w_probe]) begin
            w_found  = 1'b1;
            w_winner = w_probe;
         end
      end
   end

   always_comb begin
      w_selA = '0;
      w_selB = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_winner == IDW'(k)) begin
            w_selA = req_a[64*k +: 64];
            w_selB = req_b[64*k +: 64];
         end
      end
   end

   // Grant is gated by rst so no transfer can be offered in a reset cycle
   always_comb begin
      w_grant = '0;
      if (w_found && (r_state == ST_IDLE) && !rst) begin
         w_grant[w_winner] = 1'b1;
      end
   end

   assign w_ptrNext = IDW'((int'(w_winner) + 1) % NREQ);
   assign req_ready = w_grant;

   adder64 u_adder (
      .i_a   (r_aQ),
      .i_b   (r_bQ),
      .i_c0  (1'b0),
      .o_sum (w_sum),
      .o_c64 (w_c64)
   );

`ifdef ADDARB_OVF_EN
   logic r_ovf;
   logic w_ovf;
   assign w_ovf   = (r_aQ[63] == r_bQ[63]) && (w_sum[63] != r_aQ[63]);
   assign rsp_ovf = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == ST_CALC) begin
         r_ovf <= w_ovf;
      end
   end
`endif

   // Operands are captured only at the handshake; the response is held until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_idQ      <= '0;
         r_aQ       <= '0;
         r_bQ       <= '0;
         r_rspValid <= 1'b0;
         r_rspId    <= '0;
         r_rspSum   <= '0;
         r_rspCout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_aQ    <= w_selA;
                  r_bQ    <= w_selB;
                  r_idQ   <= w_winner;
                  r_ptr   <= w_ptrNext;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_rspSum   <= w_sum;
               r_rspCout  <= w_c64;
               r_rspId    <= r_idQ;
               r_rspValid <= 1'b1;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_rspValid <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rspValid;
   assign rsp_id    = r_rspId;
   assign rsp_sum   = r_rspSum;
   assign rsp_cout  = r_rspCout;

endmodule

// File: tb/tb_adder64_rr_sched.sv
// Self-checking bench for adder64_rr_sched: directed scenarios plus randomized traffic
// compared against a queue-free arbitration/arithmetic reference model.

module tb_adder64_rr_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*64-1:0]  req_a;
   logic [NREQ*64-1:0]  req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [63:0]         rsp_sum;
   logic                rsp_cout;
`ifdef ADDARB_OVF_EN
   logic                rsp_ovf;
`endif

   int compared   = 0;
   int mismatched = 0;
   int modelPtr   = 0;
   logic [63:0] opA [NREQ];
   logic [63:0] opB [NREQ];

   always #5 clk = ~clk;

   adder64_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
`ifdef ADDARB_OVF_EN
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
`else
      .rsp_cout  (rsp_cout)
`endif
   );

   // Reference arbitration: first valid requester at or after the pointer, wrapping
   function automatic int modelWinner(input logic [NREQ-1:0] valids, input int ptr);
      int cand;
      for (int step = 0; step < NREQ; step++) begin
         cand = (ptr + step) % NREQ;
         if (valids[cand[IDW-1:0]]) return cand;
      end
      return -1;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic loadOperands();
      for (int i = 0; i < NREQ; i++) begin
         req_a[64*i +: 64] = opA[i];
         req_b[64*i +: 64] = opB[i];
      end
   endtask

   task automatic randomizeOperands();
      for (int i = 0; i < NREQ; i++) begin
         opA[i] = {$urandom, $urandom};
         opB[i] = {$urandom, $urandom};
      end
      loadOperands();
   endtask

   task automatic applyStimulusReset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      nextCycle();
      nextCycle();
      rst      = 1'b0;
      modelPtr = 0;
   endtask

   task automatic test_reset();
      logic [64:0] expFull;
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      randomizeOperands();
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         #1;
         compared++;
         if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
         compared++;
         if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
         compared++;
         if (rsp_sum !== 64'h0 || rsp_id !== 2'd0 || rsp_cout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rsp_fields: got id=%0d sum=%h cout=%b expected all zero", rsp_id, rsp_sum, rsp_cout);
         end
`ifdef ADDARB_OVF_EN
         compared++;
         if (rsp_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf); end
`endif
      end
      rst = 1'b0;
      #1;
      compared++;
      if (req_ready !== 4'b0001) begin mismatched++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready); end
      expFull  = {1'b0, opA[0]} + {1'b0, opB[0]};
      modelPtr = 1;
      nextCycle();
      req_valid = '0;
      #1;
      compared++;
      if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_calc_valid: got %b expected 0", rsp_valid); end
      nextCycle();
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_first_rsp: got valid=%b id=%0d expected valid=1 id=0", rsp_valid, rsp_id);
      end
      compared++;
      if ({rsp_cout, rsp_sum} !== expFull) begin mismatched++; $display("[TB] FAIL reset_first_sum: got %h expected %h", {rsp_cout, rsp_sum}, expFull); end
      nextCycle();
   endtask

   task automatic test_single_add();
      applyStimulusReset();
      rsp_ready = 1'b1;
      randomizeOperands();
      opA[1] = 64'h0000_0001_FFFF_FFFF;
      opB[1] = 64'h1;
      loadOperands();
      req_valid = 4'b0010;
      #1;
      compared++;
      if (req_ready !== 4'b0010) begin mismatched++; $display("[TB] FAIL single_grant: got %b expected 0010", req_ready); end
      modelPtr = (modelWinner(4'b0010, modelPtr) + 1) % NREQ;
      nextCycle();
      req_valid = '0;
      #1;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL single_calc: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
      end
      nextCycle();
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
         mismatched++;
         $display("[TB] FAIL single_rsp: got valid=%b id=%0d expected valid=1 id=1", rsp_valid, rsp_id);
      end
      compared++;
      if (rsp_sum !== 64'h0000_0002_0000_0000 || rsp_cout !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_sum: got %h cout=%b expected 0000000200000000 cout=0", rsp_sum, rsp_cout);
      end
      nextCycle();
   endtask

   task automatic test_carry_out();
      int r;
      int w;
      logic [NREQ-1:0] expGrant;
      r = $urandom_range(0, NREQ-1);
      randomizeOperands();
      opA[r] = 64'hFFFF_FFFF_FFFF_FFFF;
      opB[r] = 64'h2;
      loadOperands();
      rsp_ready = 1'b1;
      req_valid = '0;
      req_valid[r] = 1'b1;
      w = modelWinner(req_valid, modelPtr);
      expGrant = '0;
      if (w >= 0) expGrant[w[IDW-1:0]] = 1'b1;
      #1;
      compared++;
      if (req_ready !== expGrant) begin mismatched++; $display("[TB] FAIL carry_grant: got %b expected %b", req_ready, expGrant); end
      modelPtr = (w + 1) % NREQ;
      nextCycle();
      req_valid = '0;
      nextCycle();
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(r)) begin
         mismatched++;
         $display("[TB] FAIL carry_rsp: got valid=%b id=%0d expected valid=1 id=%0d", rsp_valid, rsp_id, r);
      end
      compared++;
      if (rsp_sum !== 64'h1 || rsp_cout !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL carry_sum: got %h cout=%b expected 0000000000000001 cout=1", rsp_sum, rsp_cout);
      end
      nextCycle();
   endtask

   task automatic test_fairness();
      int w;
      logic [64:0] expFull;
      logic [NREQ-1:0] expGrant;
      applyStimulusReset();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int t = 0; t < 8; t++) begin
         randomizeOperands();
         #1;
         w = t % NREQ;
         expGrant = '0;
         expGrant[w[IDW-1:0]] = 1'b1;
         compared++;
         if (req_ready !== expGrant) begin mismatched++; $display("[TB] FAIL fair_grant_%0d: got %b expected %b", t, req_ready, expGrant); end
         expFull  = {1'b0, opA[w]} + {1'b0, opB[w]};
         modelPtr = (w + 1) % NREQ;
         nextCycle();
         #1;
         compared++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL fair_calc_%0d: got valid=%b ready=%b expected 0/0000", t, rsp_valid, req_ready);
         end
         nextCycle();
         #1;
         compared++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w)) begin
            mismatched++;
            $display("[TB] FAIL fair_rsp_%0d: got valid=%b id=%0d expected valid=1 id=%0d", t, rsp_valid, rsp_id, w);
         end
         compared++;
         if ({rsp_cout, rsp_sum} !== expFull) begin mismatched++; $display("[TB] FAIL fair_sum_%0d: got %h expected %h", t, {rsp_cout, rsp_sum}, expFull); end
         nextCycle();
      end
   endtask

   task automatic test_backpressure();
      int w;
      logic [64:0] expFull;
      logic [NREQ-1:0] expGrant;
      randomizeOperands();
      req_valid = '1;
      rsp_ready = 1'b0;
      w = modelWinner(req_valid, modelPtr);
      expGrant = '0;
      if (w >= 0) expGrant[w[IDW-1:0]] = 1'b1;
      #1;
      compared++;
      if (req_ready !== expGrant) begin mismatched++; $display("[TB] FAIL bp_grant: got %b expected %b", req_ready, expGrant); end
      expFull  = {1'b0, opA[w]} + {1'b0, opB[w]};
      modelPtr = (w + 1) % NREQ;
      nextCycle();
      nextCycle();
      for (int j = 0; j < 6; j++) begin
         if (j > 0) nextCycle();
         randomizeOperands();
         rsp_ready = (j == 5);
         #1;
         compared++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || req_ready !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL bp_hold_%0d: got valid=%b id=%0d ready=%b expected 1/%0d/0000", j, rsp_valid, rsp_id, req_ready, w);
         end
         compared++;
         if ({rsp_cout, rsp_sum} !== expFull) begin mismatched++; $display("[TB] FAIL bp_sum_%0d: got %h expected %h", j, {rsp_cout, rsp_sum}, expFull); end
      end
      nextCycle();
      w = modelWinner(req_valid, modelPtr);
      expGrant = '0;
      if (w >= 0) expGrant[w[IDW-1:0]] = 1'b1;
      #1;
      compared++;
      if (req_ready !== expGrant || rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_next_grant: got ready=%b valid=%b expected %b/0", req_ready, rsp_valid, expGrant);
      end
      expFull  = {1'b0, opA[w]} + {1'b0, opB[w]};
      modelPtr = (w + 1) % NREQ;
      nextCycle();
      req_valid = '0;
      nextCycle();
      #1;
      compared++;
      if (rsp_id !== IDW'(w) || {rsp_cout, rsp_sum} !== expFull) begin
         mismatched++;
         $display("[TB] FAIL bp_next_rsp: got id=%0d %h expected id=%0d %h", rsp_id, {rsp_cout, rsp_sum}, w, expFull);
      end
      nextCycle();
   endtask

   task automatic test_reset_midop();
      int w;
      logic [NREQ-1:0] expGrant;
      randomizeOperands();
      rsp_ready = 1'b1;
      req_valid = 4'b1110;
      w = modelWinner(req_valid, modelPtr);
      expGrant = '0;
      if (w >= 0) expGrant[w[IDW-1:0]] = 1'b1;
      #1;
      compared++;
      if (req_ready !== expGrant) begin mismatched++; $display("[TB] FAIL midrst_grant: got %b expected %b", req_ready, expGrant); end
      nextCycle();
      req_valid = '0;
      rst = 1'b1;
      #1;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL midrst_calc: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
      end
      nextCycle();
      rst = 1'b0;
      modelPtr = 0;
      opA[0] = 64'h7FFF_FFFF_FFFF_FFFF;
      opB[0] = 64'h1;
      loadOperands();
      req_valid = '1;
      #1;
      compared++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 64'h0 || rsp_id !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL midrst_cleared: got valid=%b id=%0d sum=%h expected 0/0/0", rsp_valid, rsp_id, rsp_sum);
      end
      compared++;
      if (req_ready !== 4'b0001) begin mismatched++; $display("[TB] FAIL midrst_first_grant: got %b expected 0001", req_ready); end
      modelPtr = 1;
      nextCycle();
      req_valid = '0;
      #1;
      compared++;
      if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_stale_rsp: got %b expected 0", rsp_valid); end
      nextCycle();
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL midrst_rsp: got valid=%b id=%0d expected valid=1 id=0", rsp_valid, rsp_id);
      end
      compared++;
      if (rsp_sum !== 64'h8000_0000_0000_0000 || rsp_cout !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrst_sum: got %h cout=%b expected 8000000000000000 cout=0", rsp_sum, rsp_cout);
      end
`ifdef ADDARB_OVF_EN
      compared++;
      if (rsp_ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_ovf: got %b expected 1", rsp_ovf); end
`endif
      nextCycle();
   endtask

   task automatic test_random();
      int w;
      int stall;
      logic [64:0] expFull;
      logic [NREQ-1:0] expGrant;
      logic [NREQ-1:0] mask;
      for (int n = 0; n < 14; n++) begin
         mask = NREQ'($urandom_range(0, 15));
         randomizeOperands();
         req_valid = mask;
         rsp_ready = 1'b0;
         w = modelWinner(mask, modelPtr);
         expGrant = '0;
         if (w >= 0) expGrant[w[IDW-1:0]] = 1'b1;
         #1;
         compared++;
         if (req_ready !== expGrant) begin mismatched++; $display("[TB] FAIL rand_grant_%0d: got %b expected %b", n, req_ready, expGrant); end
         if (w < 0) begin
            nextCycle();
            continue;
         end
         expFull  = {1'b0, opA[w]} + {1'b0, opB[w]};
         modelPtr = (w + 1) % NREQ;
         stall    = $urandom_range(0, 2);
         nextCycle();
         req_valid = NREQ'($urandom_range(0, 15));
         randomizeOperands();
         #1;
         compared++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rand_calc_%0d: got valid=%b ready=%b expected 0/0000", n, rsp_valid, req_ready);
         end
         nextCycle();
         rsp_ready = (stall == 0);
         #1;
         compared++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w)) begin
            mismatched++;
            $display("[TB] FAIL rand_rsp_%0d: got valid=%b id=%0d expected valid=1 id=%0d", n, rsp_valid, rsp_id, w);
         end
         compared++;
         if ({rsp_cout, rsp_sum} !== expFull) begin mismatched++; $display("[TB] FAIL rand_sum_%0d: got %h expected %h", n, {rsp_cout, rsp_sum}, expFull); end
`ifdef ADDARB_OVF_EN
         compared++;
         if (rsp_ovf !== ((opA[w][63] == opB[w][63]) && (expFull[63] != opA[w][63]))) begin
            mismatched++;
            $display("[TB] FAIL rand_ovf_%0d: got %b", n, rsp_ovf);
         end
`endif
         for (int j = 1; j <= stall; j++) begin
            nextCycle();
            rsp_ready = (j == stall);
            #1;
            compared++;
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== expFull) begin
               mismatched++;
               $display("[TB] FAIL rand_stall_%0d: got valid=%b %h expected 1 %h", n, rsp_valid, {rsp_cout, rsp_sum}, expFull);
            end
         end
         nextCycle();
      end
      req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      test_reset();
      test_single_add();
      test_carry_out();
      test_fairness();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
